// File: rtl/data_bus_adapter_if.sv
// Wishbone B4 pipelined bus between the data-bus adapter (master) and the
// system interconnect (slave). Data fields are named from the master side:
// wb_dat_w travels master->slave and wb_dat_r travels slave->master.
interface data_bus_adapter_if #(
  parameter int XLEN = 32
);
  logic            wb_cyc;
  logic            wb_stb;
  logic            wb_we;
  logic [XLEN-1:0] wb_adr;
  logic [3:0]      wb_sel;
  logic [XLEN-1:0] wb_dat_w;
  logic [XLEN-1:0] wb_dat_r;
  logic            wb_ack;
  logic            wb_err;
  logic            wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    input  wb_dat_r, wb_ack, wb_err, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    output wb_dat_r, wb_ack, wb_err, wb_stall
  );
endinterface

// File: rtl/data_bus_adapter.sv
// Data-bus adapter between the hart memory stage and a Wishbone B4 pipelined
// bus. Accepts one load/store at a time, steers store bytes onto lanes,
// extends load data, and reports completion or a fault with a one-cycle pulse.
// Only XLEN = 32 is supported.
module data_bus_adapter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stb,
  input  logic               i_we,
  input  logic [2:0]         i_sel,
  input  logic [XLEN-1:0]    i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_valid,
  output logic               o_err,
  output logic [1:0]         o_err_cause,
  output logic               o_busy,
  data_bus_adapter_if.master wb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_BAD     = 2'b01,
    CAUSE_BUS     = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_t;

  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_H  = 3'b001;
  localparam logic [2:0] SEL_W  = 3'b010;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;

  // The counter only has to reach TIMEOUT_CYCLES-1; the edge after that aborts.
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  cause_t           r_cause;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [1:0]       r_lane;
  logic [XLEN-1:0]  r_rdata;
  logic             r_valid;
  logic             r_err;
  logic             r_wb_cyc;
  logic             r_wb_stb;
  logic             r_wb_we;
  logic [XLEN-1:0]  r_wb_adr;
  logic [3:0]       r_wb_sel;
  logic [XLEN-1:0]  r_wb_dat;

  logic             w_bad;
  logic [3:0]       w_sel;
  logic [XLEN-1:0]  w_dat;
  logic             w_resp;

  // Right-align the addressed lane of the bus word, then sign/zero extend.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] dat,
                                                  input logic [1:0]      lane,
                                                  input logic [2:0]      sel);
    logic [XLEN-1:0] sh;
    sh = dat >> {lane, 3'b000};
    case (sel)
      SEL_B:   return {{24{sh[7]}}, sh[7:0]};
      SEL_H:   return {{16{sh[15]}}, sh[15:0]};
      SEL_BU:  return {24'b0, sh[7:0]};
      SEL_HU:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Decode the incoming request: alignment check, byte lanes, replicated store data.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    w_bad = 1'b0;
    w_sel = 4'b0000;
    w_dat = '0;
    case (i_sel)
      SEL_B, SEL_BU: begin
        w_sel = 4'b0001 << i_addr[1:0];
        w_dat = {4{i_wdata[7:0]}};
      end
      SEL_H, SEL_HU: begin
        w_bad = i_addr[0];
        w_sel = 4'b0011 << {i_addr[1], 1'b0};
        w_dat = {2{i_wdata[15:0]}};
      end
      SEL_W: begin
        w_bad = |i_addr[1:0];
        w_sel = 4'b1111;
        w_dat = i_wdata;
      end
      default: w_bad = 1'b1;
    endcase
    if (!i_we) begin
      w_dat = '0;
    end
  end

  // A slave response counts only while the strobe has been taken (REQ, not stalled) or in WAIT.
  assign w_resp = (wb.wb_ack | wb.wb_err) &
                  (((r_state == S_REQ) && !wb.wb_stall) || (r_state == S_WAIT));

  // Request/response FSM; every output except o_busy is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cause  <= CAUSE_NONE;
      r_cnt    <= '0;
      r_sel    <= 3'b000;
      r_lane   <= 2'b00;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_wb_cyc <= 1'b0;
      r_wb_stb <= 1'b0;
      r_wb_we  <= 1'b0;
      r_wb_adr <= '0;
      r_wb_sel <= 4'b0000;
      r_wb_dat <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (i_stb) begin
            r_sel  <= i_sel;
            r_lane <= i_addr[1:0];
            if (w_bad) begin
              r_err   <= 1'b1;
              r_cause <= CAUSE_BAD;
              r_state <= S_RESP;
            end else begin
              r_wb_cyc <= 1'b1;
              r_wb_stb <= 1'b1;
              r_wb_we  <= i_we;
              r_wb_adr <= {i_addr[XLEN-1:2], 2'b00};
              r_wb_sel <= w_sel;
              r_wb_dat <= w_dat;
              r_state  <= S_REQ;
            end
          end
        end

        S_REQ, S_WAIT: begin
          if (w_resp) begin
            r_wb_cyc <= 1'b0;
            r_wb_stb <= 1'b0;
            r_state  <= S_RESP;
            if (wb.wb_err) begin
              r_err   <= 1'b1;
              r_cause <= CAUSE_BUS;
            end else begin
              r_valid <= 1'b1;
              r_rdata <= r_wb_we ? '0 : extend_load(wb.wb_dat_r, r_lane, r_sel);
            end
          end else if (r_cnt == CNT_LAST) begin
            r_wb_cyc <= 1'b0;
            r_wb_stb <= 1'b0;
            r_err    <= 1'b1;
            r_cause  <= CAUSE_TIMEOUT;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_REQ) && !wb.wb_stall) begin
              r_wb_stb <= 1'b0;
              r_state  <= S_WAIT;
            end
          end
        end

        S_RESP: begin
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_cause <= CAUSE_NONE;
          r_rdata <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_rdata     = r_rdata;
  assign o_valid     = r_valid;
  assign o_err       = r_err;
  assign o_err_cause = r_cause;

  assign wb.wb_cyc   = r_wb_cyc;
  assign wb.wb_stb   = r_wb_stb;
  assign wb.wb_we    = r_wb_we;
  assign wb.wb_adr   = r_wb_adr;
  assign wb.wb_sel   = r_wb_sel;
  assign wb.wb_dat_w = r_wb_dat;

endmodule

// File: doc/data_bus_adapter.md
Name: data_bus_adapter

Overview:
- Sits directly downstream of the hart's memory stage, between the hart's raw data-access port and the system Wishbone B4 pipelined bus.
- Latches one load/store request and performs byte-lane steering for stores.
- Sign/zero-extends loads, detects misaligned accesses and bus faults, and reports completion with a one-cycle pulse plus a busy/stall flag.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, number of cycles with o_wb_cyc high and no ack/err before the access is aborted; must be ≥1.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- i_stb  in  1  core request strobe (single cycle or held)
- i_we  in  1  1 = store, 0 = load
- i_sel  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; others invalid
- i_addr  in  XLEN  byte address
- i_wdata  in  XLEN  store data, right-aligned
- o_rdata  out  XLEN  extended load data; 0 for stores/errors
- o_valid  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle fault pulse; mutually exclusive with o_valid
- o_err_cause  out  2  00 none, 01 bad access (misaligned/invalid sel), 10 bus error, 11 timeout
- o_busy  out  1  high whenever state != IDLE
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe
- o_wb_we  out  1  bus write enable
- o_wb_adr  out  XLEN  word address, bits [1:0] = 0
- o_wb_sel  out  4  byte lanes
- o_wb_dat  out  XLEN  write data
- i_wb_dat  in  XLEN  read data
- i_wb_ack  in  1  slave acknowledge
- i_wb_err  in  1  slave error
- i_wb_stall  in  1  slave stall

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - All outputs 0: o_wb_*, o_valid, o_err, o_err_cause, o_rdata, o_busy.
  - Timeout counter = 0.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered except o_busy (decoded from state).
- IDLE:
  - Sample i_stb high at edge k: latch we, sel, addr[1:0], wdata.
  - Bad access = H/HU with addr[0]=1, W with addr[1:0]≠0, or invalid sel. On bad access, go to RESP with cause 01; no bus cycle is issued.
  - Otherwise from edge k: o_wb_cyc=o_wb_stb=1, adr={addr[31:2],00}, next state REQ.
- Store lane rules:
  - B: sel = 0001<<addr[1:0], dat = {4{wdata[7:0]}}.
  - H: sel = 0011<<{addr[1],0}, dat = {2{wdata[15:0]}}.
  - W: sel = 1111, dat = wdata.
  - Loads use the same sel values; o_wb_dat = 0.
- REQ:
  - Hold o_wb_stb and all o_wb_* fields stable while i_wb_stall=1.
  - At an edge with i_wb_stall=0: drop stb, go to WAIT.
- Acknowledge handling:
  - i_wb_ack or i_wb_err is honoured at any edge in REQ (only if stall=0) or WAIT.
  - On ack/err: drop cyc and stb, go to RESP. err takes priority over a simultaneous ack (cause 10).
- Timeout counter:
  - Increments each edge in REQ/WAIT; cleared on entering IDLE.
  - On reaching TIMEOUT_CYCLES without ack/err: drop cyc/stb, go to RESP with cause 11.
- RESP (exactly one cycle):
  - Success: o_valid=1.
  - Fault: o_err=1 with o_err_cause set.
  - Next edge: clear pulses, o_err_cause=00, return to IDLE.
  - Latency: 3 cycles from acceptance to o_valid for a zero-wait, zero-stall slave.
- Load extension:
  - Shift i_wb_dat right by 8*addr[1:0], captured at the ack edge.
  - B/H: sign-extend bit 7/15. BU/HU: zero-extend. W: unchanged.
  - o_rdata holds its value through RESP, then returns to 0.
- i_stb while o_busy=1 is ignored. The core must hold or re-issue the request.
- i_wb_ack or i_wb_err arriving in IDLE or RESP (late or spurious) is ignored.
- Reset mid-transaction aborts immediately: cyc/stb fall asynchronously, and neither o_valid nor o_err is produced.

Test Plan:
- SB 0xA5 at 0x1003, slave acks 2 cycles after stb accepted:
  - adr=0x1000, sel=1000, dat=0xA5A5A5A5, we=1.
  - o_valid pulses once, o_rdata=0.
- LB at 0x2002, i_wb_dat=0x12F45678:
  - sel=0100, o_rdata=0xFFFFFFF4.
  - Repeat as LBU: o_rdata=0x000000F4.
  - Repeat as LHU at 0x2002: o_rdata=0x000012F4.
- LH at 0x3001, and i_sel=011 at 0x3000:
  - o_wb_cyc never rises.
  - o_err pulses one cycle after acceptance with cause 01.
- LW at 0x4000, i_wb_stall held 3 cycles:
  - stb, adr and sel stable for 4 cycles.
  - Ack with 0xDEADBEEF gives o_rdata=0xDEADBEEF and o_valid.
  - i_stb pulsed during busy is ignored.
- TIMEOUT_CYCLES=8, slave never responds:
  - cyc drops after 8 cycles, o_err with cause 11.
  - A late ack afterwards produces no pulse.
- rst asserted during WAIT:
  - cyc/stb low immediately, no o_valid/o_err.
  - A subsequent SW 0x11223344 at 0x8 completes normally with sel=1111.
- err and ack asserted together:
  - o_err with cause 10, o_valid stays 0.
